hazard_unit: RTL and testbench
==============================

# hazard_unit

Hazard detection and forwarding unit for the 5-stage ARM-like pipeline, and the consumer of the pipeline controller's hazard outputs. It tracks source and destination register numbers through Execute, Memory and Writeback in its own pipeline registers. From these it generates the Fetch/Decode stall and flush signals and the Execute-stage forwarding selects. It also keeps two saturating performance counters for load-use stalls and taken branches.

## Interface
- REG_BITS, 4, width of register-number fields
- CNT_WIDTH, 16, width of each performance counter
- clk  input  1  global clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- RA1D  input  REG_BITS  first source register number in Decode
- RA2D  input  REG_BITS  second source register number in Decode
- WA3D  input  REG_BITS  destination register number in Decode
- MemtoRegE_Haz  input  1  load instruction in Execute
- RegWriteM_Haz  input  1  register write pending in Memory
- RegWriteW  input  1  register write in Writeback
- PCSrcD_Haz, PCSrcE_Haz, PCSrcM_Haz  input  1 each  PC write pending in Decode, Execute, Memory
- PCSrcW  input  1  PC write retiring in Writeback
- BranchTakenE  input  1  branch resolved taken in Execute
- StallF  output  1  hold the PC / Fetch register
- StallD  output  1  hold the Decode register
- FlushD  output  1  clear the Decode register
- FlushE  output  1  clear the Execute register; drives the controller's FlushE
- ForwardAE  output  2  SrcA select: 00 = register file, 01 = Writeback result, 10 = Memory ALU result
- ForwardBE  output  2  SrcB select, same encoding as ForwardAE
- ldr_stall_count  output  CNT_WIDTH  number of load-use stall cycles
- branch_flush_count  output  CNT_WIDTH  number of taken-branch cycles

## Operation
- **Internal registers**
  - Execute stage: RA1E, RA2E, WA3E.
  - Memory stage: WA3M.
  - Writeback stage: WA3W.
- **Register update on each clock edge**
  - If FlushE is high, RA1E, RA2E and WA3E load 0. Otherwise they load RA1D, RA2D, WA3D.
  - WA3M loads WA3E, and WA3W loads WA3M, unconditionally.
  - A flushed entry of 0 cannot cause a false forward. The controller clears RegWrite and MemtoReg for that slot at the same edge.
- **Forwarding (combinational)**
  - ForwardAE = 10 if RegWriteM_Haz and RA1E == WA3M.
  - Else ForwardAE = 01 if RegWriteW and RA1E == WA3W.
  - Else ForwardAE = 00.
  - ForwardBE uses the same rules with RA2E.
  - Memory has priority over Writeback when both match.
- **Load-use stall**
  - LDRstall = MemtoRegE_Haz and (RA1D == WA3E or RA2D == WA3E).
- **PC write pending**
  - PCWrPending = PCSrcD_Haz or PCSrcE_Haz or PCSrcM_Haz.
- **Control outputs (combinational)**
  - StallF = LDRstall or PCWrPending.
  - StallD = LDRstall.
  - FlushD = PCWrPending or PCSrcW or BranchTakenE.
  - FlushE = LDRstall or BranchTakenE.
- **Simultaneous events**
  - LDRstall and BranchTakenE together: FlushE = 1, StallD = 1, FlushD = 1. The flush wins at the Decode register; the Decode register must apply flush over stall.
- **Performance counters**
  - ldr_stall_count increments on each non-reset cycle with LDRstall = 1.
  - branch_flush_count increments on each non-reset cycle with BranchTakenE = 1.
  - Both saturate at all-ones and never wrap.

## Timing
- All detection and forwarding outputs are combinational from inputs and internal registers. There is no added latency.
- Internal register numbers advance one stage per clock edge, in lockstep with the controller's pipeline registers.
- A load-use stall lasts exactly one cycle. On the edge after detection, the bubble places MemtoRegE_Haz = 0 and WA3E = 0, so LDRstall drops.
- **Reset (synchronous, active-high)**
  - On an edge with reset = 1, all internal registers and both counters load 0.
  - While reset = 1, outputs are forced: StallF = 0, StallD = 0, FlushD = 1, FlushE = 1, ForwardAE = 00, ForwardBE = 00.
  - The forced FlushE = 1 clears the controller's Execute register, which has no reset of its own.
  - Reset asserted mid-stall or mid-branch overrides all hazard logic in the same cycle.
- After reset deasserts, outputs follow the rules in Operation from the next cycle.

## Test plan
- **Memory forwarding:** WA3D = 3, then RA1D = 3 on the next cycle; drive RegWriteM_Haz = 1 when the producer reaches Memory -> ForwardAE = 10, ForwardBE = 00.
- **Priority:** RA2E = 5, WA3M = 5, WA3W = 5, RegWriteM_Haz = 1, RegWriteW = 1 -> ForwardBE = 10. Then drop RegWriteM_Haz -> ForwardBE = 01.
- **Load-use:** WA3E = 2, MemtoRegE_Haz = 1, RA2D = 2 -> StallF = StallD = FlushE = 1 for exactly one cycle; RA1E/RA2E/WA3E = 0 on the next cycle; ldr_stall_count goes 0 -> 1.
- **Taken branch:** BranchTakenE = 1 for one cycle -> FlushD = 1, FlushE = 1, StallF = 0, branch_flush_count +1. Separately, PCSrcD_Haz = 1 -> StallF = 1 and FlushD = 1.
- **Reset mid-stall:** assert reset while LDRstall = 1 -> same cycle StallF = 0, FlushE = 1, FlushD = 1; after the edge, counters = 0 and all internal registers = 0.
- **Saturation:** CNT_WIDTH = 4, hold the load-use condition for 20 cycles -> ldr_stall_count stops at 15.

Source files
------------

// File: rtl/hazard_unit.sv
// hazard_unit
// Hazard detection and forwarding for the 5-stage ARM-like pipeline.
// It tracks register numbers through Execute, Memory and Writeback, and
// from them produces the Fetch/Decode stall and flush controls and the
// Execute-stage operand forwarding selects. It also keeps two saturating
// performance counters, one for load-use stalls and one for taken branches.
//
// Ports
//   clk, reset                       clock, synchronous active-high reset
//   RA1D, RA2D, WA3D                 Decode source/destination register numbers
//   MemtoRegE_Haz                    load in Execute
//   RegWriteM_Haz, RegWriteW         register write pending in Memory / Writeback
//   PCSrcD_Haz/E_Haz/M_Haz, PCSrcW   PC write in flight / retiring
//   BranchTakenE                     branch resolved taken in Execute
//   StallF, StallD, FlushD, FlushE   pipeline register controls (combinational)
//   ForwardAE, ForwardBE             SrcA/SrcB select: 00 RF, 01 WB result, 10 Mem ALU result
//   ldr_stall_count                  load-use stall cycles (saturating)
//   branch_flush_count               taken-branch cycles (saturating)
module hazard_unit #(
    parameter int unsigned REG_BITS  = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [REG_BITS-1:0]  RA1D,
    input  logic [REG_BITS-1:0]  RA2D,
    input  logic [REG_BITS-1:0]  WA3D,
    input  logic                 MemtoRegE_Haz,
    input  logic                 RegWriteM_Haz,
    input  logic                 RegWriteW,
    input  logic                 PCSrcD_Haz,
    input  logic                 PCSrcE_Haz,
    input  logic                 PCSrcM_Haz,
    input  logic                 PCSrcW,
    input  logic                 BranchTakenE,
    output logic                 StallF,
    output logic                 StallD,
    output logic                 FlushD,
    output logic                 FlushE,
    output logic [1:0]           ForwardAE,
    output logic [1:0]           ForwardBE,
    output logic [CNT_WIDTH-1:0] ldr_stall_count,
    output logic [CNT_WIDTH-1:0] branch_flush_count
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    logic [REG_BITS-1:0] RA1E, RA2E, WA3E, WA3M, WA3W;
    logic                ldrStall;
    logic                pcWrPending;

    // Raw hazard conditions, before the reset override
    assign ldrStall    = MemtoRegE_Haz && ((RA1D == WA3E) || (RA2D == WA3E));
    assign pcWrPending = PCSrcD_Haz || PCSrcE_Haz || PCSrcM_Haz;

    // Stall/flush/forward controls; reset forces both flushes so the
    // controller's unreset Execute register is cleared while reset is held
    always_comb begin
        StallF    = 1'b0;
        StallD    = 1'b0;
        FlushD    = 1'b1;
        FlushE    = 1'b1;
        ForwardAE = FWD_RF;
        ForwardBE = FWD_RF;
        if (!reset) begin
            StallF = ldrStall || pcWrPending;
            StallD = ldrStall;
            FlushD = pcWrPending || PCSrcW || BranchTakenE;
            FlushE = ldrStall || BranchTakenE;

            // Memory result is younger, so it wins over Writeback
            if (RegWriteM_Haz && (RA1E == WA3M))
                ForwardAE = FWD_MEM;
            else if (RegWriteW && (RA1E == WA3W))
                ForwardAE = FWD_WB;

            if (RegWriteM_Haz && (RA2E == WA3M))
                ForwardBE = FWD_MEM;
            else if (RegWriteW && (RA2E == WA3W))
                ForwardBE = FWD_WB;
        end
    end

    // Register-number pipeline, in lockstep with the controller's registers
    always_ff @(posedge clk) begin
        if (reset) begin
            RA1E <= '0;
            RA2E <= '0;
            WA3E <= '0;
            WA3M <= '0;
            WA3W <= '0;
        end else begin
            if (FlushE) begin
                RA1E <= '0;
                RA2E <= '0;
                WA3E <= '0;
            end else begin
                RA1E <= RA1D;
                RA2E <= RA2D;
                WA3E <= WA3D;
            end
            WA3M <= WA3E;
            WA3W <= WA3M;
        end
    end

    // Saturating performance counters
    always_ff @(posedge clk) begin
        if (reset) begin
            ldr_stall_count    <= '0;
            branch_flush_count <= '0;
        end else begin
            if (ldrStall && (ldr_stall_count != '1))
                ldr_stall_count <= ldr_stall_count + CNT_WIDTH'(1);
            if (BranchTakenE && (branch_flush_count != '1))
                branch_flush_count <= branch_flush_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_hazard_unit.sv
// tb_hazard_unit
// Directed self-checking bench for hazard_unit. Inputs change 1 time unit
// after the rising edge; outputs are sampled on the falling edge. A second
// instance with 4-bit counters shares the inputs to observe saturation.
module tb_hazard_unit;

    localparam int unsigned REG_BITS = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [REG_BITS-1:0] RA1D, RA2D, WA3D;
    logic                MemtoRegE_Haz, RegWriteM_Haz, RegWriteW;
    logic                PCSrcD_Haz, PCSrcE_Haz, PCSrcM_Haz, PCSrcW, BranchTakenE;
    logic                StallF, StallD, FlushD, FlushE;
    logic [1:0]          ForwardAE, ForwardBE;
    logic [15:0]         ldr_stall_count, branch_flush_count;

    logic                sStallF, sStallD, sFlushD, sFlushE;
    logic [1:0]          sForwardAE, sForwardBE;
    logic [3:0]          sLdrCount, sBrCount;

    int nChecks = 0;
    int nErrors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.REG_BITS(REG_BITS), .CNT_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .MemtoRegE_Haz(MemtoRegE_Haz), .RegWriteM_Haz(RegWriteM_Haz), .RegWriteW(RegWriteW),
        .PCSrcD_Haz(PCSrcD_Haz), .PCSrcE_Haz(PCSrcE_Haz), .PCSrcM_Haz(PCSrcM_Haz),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
        .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ldr_stall_count(ldr_stall_count), .branch_flush_count(branch_flush_count)
    );

    hazard_unit #(.REG_BITS(REG_BITS), .CNT_WIDTH(4)) dutSmall (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .WA3D(WA3D),
        .MemtoRegE_Haz(MemtoRegE_Haz), .RegWriteM_Haz(RegWriteM_Haz), .RegWriteW(RegWriteW),
        .PCSrcD_Haz(PCSrcD_Haz), .PCSrcE_Haz(PCSrcE_Haz), .PCSrcM_Haz(PCSrcM_Haz),
        .PCSrcW(PCSrcW), .BranchTakenE(BranchTakenE),
        .StallF(sStallF), .StallD(sStallD), .FlushD(sFlushD), .FlushE(sFlushE),
        .ForwardAE(sForwardAE), .ForwardBE(sForwardBE),
        .ldr_stall_count(sLdrCount), .branch_flush_count(sBrCount)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clearInputs();
        RA1D = '0; RA2D = '0; WA3D = '0;
        MemtoRegE_Haz = 1'b0; RegWriteM_Haz = 1'b0; RegWriteW = 1'b0;
        PCSrcD_Haz = 1'b0; PCSrcE_Haz = 1'b0; PCSrcM_Haz = 1'b0;
        PCSrcW = 1'b0; BranchTakenE = 1'b0;
    endtask

    // Advance one edge, then settle just after it
    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        clearInputs();
        reset = 1'b1;
        nextCycle();
        nextCycle();

        // Forced outputs while reset is held
        sample();
        check("rst_StallF", 32'(StallF), 32'd0);
        check("rst_StallD", 32'(StallD), 32'd0);
        check("rst_FlushD", 32'(FlushD), 32'd1);
        check("rst_FlushE", 32'(FlushE), 32'd1);
        check("rst_FwdA", 32'(ForwardAE), 32'd0);
        check("rst_FwdB", 32'(ForwardBE), 32'd0);
        nextCycle();
        reset = 1'b0;
        sample();
        check("idle_FlushD", 32'(FlushD), 32'd0);
        check("idle_FlushE", 32'(FlushE), 32'd0);
        check("idle_ldrCnt", 32'(ldr_stall_count), 32'd0);
        check("idle_brCnt", 32'(branch_flush_count), 32'd0);

        // Memory then Writeback forwarding of r3 to SrcA
        WA3D = 4'd3;
        nextCycle();
        WA3D = 4'd0; RA1D = 4'd3;
        nextCycle();
        RegWriteM_Haz = 1'b1;
        sample();
        check("memfwd_A", 32'(ForwardAE), 32'h2);
        check("memfwd_B", 32'(ForwardBE), 32'h0);
        nextCycle();
        RegWriteM_Haz = 1'b0; RegWriteW = 1'b1;
        sample();
        check("wbfwd_A", 32'(ForwardAE), 32'h1);
        nextCycle();
        clearInputs();

        // Priority: RA2E = WA3M = WA3W = 5
        WA3D = 4'd5;
        nextCycle();
        nextCycle();
        RA2D = 4'd5;
        nextCycle();
        clearInputs();
        RegWriteM_Haz = 1'b1; RegWriteW = 1'b1;
        sample();
        check("prio_B_mem", 32'(ForwardBE), 32'h2);
        check("prio_A_none", 32'(ForwardAE), 32'h0);
        RegWriteM_Haz = 1'b0;
        #1;
        check("prio_B_wb", 32'(ForwardBE), 32'h1);
        nextCycle();
        clearInputs();

        // Load-use on r2 via RA2D
        WA3D = 4'd2;
        nextCycle();
        WA3D = 4'd7; RA1D = 4'd4; RA2D = 4'd2; MemtoRegE_Haz = 1'b1;
        sample();
        check("lu_StallF", 32'(StallF), 32'd1);
        check("lu_StallD", 32'(StallD), 32'd1);
        check("lu_FlushE", 32'(FlushE), 32'd1);
        check("lu_FlushD", 32'(FlushD), 32'd0);
        check("lu_cnt_before", 32'(ldr_stall_count), 32'd0);
        nextCycle();
        MemtoRegE_Haz = 1'b0;
        sample();
        check("lu_StallD_drop", 32'(StallD), 32'd0);
        check("lu_FlushE_drop", 32'(FlushE), 32'd0);
        check("lu_RA1E", 32'(dut.RA1E), 32'd0);
        check("lu_RA2E", 32'(dut.RA2E), 32'd0);
        check("lu_WA3E", 32'(dut.WA3E), 32'd0);
        check("lu_cnt_after", 32'(ldr_stall_count), 32'd1);
        nextCycle();
        clearInputs();

        // Taken branch for one cycle
        BranchTakenE = 1'b1;
        sample();
        check("br_FlushD", 32'(FlushD), 32'd1);
        check("br_FlushE", 32'(FlushE), 32'd1);
        check("br_StallF", 32'(StallF), 32'd0);
        check("br_StallD", 32'(StallD), 32'd0);
        nextCycle();
        BranchTakenE = 1'b0;
        sample();
        check("br_cnt", 32'(branch_flush_count), 32'd1);
        check("br_FlushE_drop", 32'(FlushE), 32'd0);

        // PC write pending in Decode
        PCSrcD_Haz = 1'b1;
        #1;
        check("pcd_StallF", 32'(StallF), 32'd1);
        check("pcd_FlushD", 32'(FlushD), 32'd1);
        check("pcd_FlushE", 32'(FlushE), 32'd0);
        nextCycle();
        PCSrcD_Haz = 1'b0; PCSrcW = 1'b1;
        sample();
        check("pcw_FlushD", 32'(FlushD), 32'd1);
        check("pcw_StallF", 32'(StallF), 32'd0);
        nextCycle();
        clearInputs();

        // Load-use and taken branch together
        WA3D = 4'd6;
        nextCycle();
        WA3D = 4'd0; RA1D = 4'd6; MemtoRegE_Haz = 1'b1; BranchTakenE = 1'b1;
        sample();
        check("both_StallD", 32'(StallD), 32'd1);
        check("both_FlushD", 32'(FlushD), 32'd1);
        check("both_FlushE", 32'(FlushE), 32'd1);
        check("both_StallF", 32'(StallF), 32'd1);
        nextCycle();
        clearInputs();
        sample();
        check("both_ldrCnt", 32'(ldr_stall_count), 32'd2);
        check("both_brCnt", 32'(branch_flush_count), 32'd2);
        nextCycle();

        // Reset asserted while a load-use stall is active
        WA3D = 4'd9;
        nextCycle();
        WA3D = 4'd0; RA1D = 4'd9; MemtoRegE_Haz = 1'b1; reset = 1'b1;
        sample();
        check("rstmid_StallF", 32'(StallF), 32'd0);
        check("rstmid_StallD", 32'(StallD), 32'd0);
        check("rstmid_FlushE", 32'(FlushE), 32'd1);
        check("rstmid_FlushD", 32'(FlushD), 32'd1);
        nextCycle();
        reset = 1'b0;
        clearInputs();
        sample();
        check("rstmid_ldrCnt", 32'(ldr_stall_count), 32'd0);
        check("rstmid_brCnt", 32'(branch_flush_count), 32'd0);
        check("rstmid_RA1E", 32'(dut.RA1E), 32'd0);
        check("rstmid_WA3E", 32'(dut.WA3E), 32'd0);
        check("rstmid_WA3M", 32'(dut.WA3M), 32'd0);
        check("rstmid_WA3W", 32'(dut.WA3W), 32'd0);

        // Held load-use on r0: the flushed WA3E stays 0, so it stalls every cycle
        MemtoRegE_Haz = 1'b1;
        for (int i = 0; i < 20; i++) nextCycle();
        MemtoRegE_Haz = 1'b0;
        sample();
        check("sat_small", 32'(sLdrCount), 32'd15);
        check("sat_wide", 32'(ldr_stall_count), 32'd20);
        check("sat_small_br", 32'(sBrCount), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nErrors);
        $finish;
    end

    // Hard stop in case the stimulus ever stalls
    initial begin
        #100000;
        $display("FAIL timeout: got no end of stimulus, expected completion");
        $fatal(1);
    end

endmodule
